mano_program_loader: RTL and testbench

MANO_PROGRAM_LOADER -- requirements
Module: mano_program_loader

---
 rtl/mano_program_loader_pkg.sv | 9 +
 rtl/mano_program_loader_checksum.sv | 16 +
 rtl/mano_program_loader.sv | 104 ++++++++++
 tb/tb_mano_program_loader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mano_program_loader_pkg.sv
// mano_program_loader_pkg: shared state encoding, header length and size defaults for the program loader.
package mano_program_loader_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, WRITE, CHECK, DONE, ERROR
  } state_t;
  localparam int HDR_LEN = 4;
  localparam int N_M_DEF = 12;
  localparam int N_L_DEF = 16;
endpackage

// File: rtl/mano_program_loader_checksum.sv
// loader_checksum: running XOR of payload bytes, cleared at the start of each load.
module loader_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);
  logic [7:0] sum_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sum_q <= '0;
    else if (clr_i) sum_q <= '0;
    else if (en_i) sum_q <= sum_q ^ data_i;
  assign sum_o = sum_q;
endmodule

// File: rtl/mano_program_loader.sv
// mano_program_loader: parses an addr/count/payload/checksum byte stream and writes words into SRAM
// while holding the CPU off; status outputs are decoded straight from the state so CLR acts at once.
module mano_program_loader
  import mano_program_loader_pkg::*;
#(
  parameter int N_M = N_M_DEF,
  parameter int N_L = N_L_DEF
) (
  input  logic           master_clock,
  input  logic           CLR,
  input  logic           start,
  input  logic           byte_valid,
  input  logic [7:0]     byte_data,
  output logic           byte_ready,
  output logic [N_M-1:0] mem_address,
  output logic [N_L-1:0] mem_data,
  output logic           mem_write,
  output logic           cpu_hold,
  output logic           load_done,
  output logic           load_error,
  output logic [N_M-1:0] words_loaded
);
  state_t         state_q, state_d;
  logic [N_M-1:0] addr_q, addr_d, cnt_q, cnt_d, words_q, words_d;
  logic [N_L-1:0] data_q, data_d;
  logic [7:0]     hi_q, hi_d, sum;
  logic           acc, sum_clr, sum_en;
  assign byte_ready   = state_q inside {ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, CHECK};
  assign acc          = byte_valid && byte_ready;
  assign sum_en       = acc && (state_q == DATA_H || state_q == DATA_L);
  assign mem_write    = state_q == WRITE;
  assign cpu_hold     = !(state_q inside {IDLE, DONE});
  assign load_done    = state_q == DONE;
  assign load_error   = state_q == ERROR;
  assign mem_address  = addr_q;
  assign mem_data     = data_q;
  assign words_loaded = words_q;
  loader_checksum u_sum (
    .clk(master_clock), .rst(CLR), .clr_i(sum_clr), .en_i(sum_en), .data_i(byte_data), .sum_o(sum)
  );
  always_ff @(posedge master_clock or posedge CLR)
    if (CLR) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      data_q  <= data_d;
      hi_q    <= hi_d;
    end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    data_d  = data_q;
    hi_d    = hi_q;
    sum_clr = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        state_d = ADDR_H;
        words_d = '0;
        sum_clr = 1'b1;
      end
      ADDR_H: if (acc) begin
        hi_d    = byte_data;
        state_d = ADDR_L;
      end
      ADDR_L: if (acc) begin
        addr_d  = N_M'({hi_q[3:0], byte_data});
        state_d = CNT_H;
      end
      CNT_H: if (acc) begin
        hi_d    = byte_data;
        state_d = CNT_L;
      end
      CNT_L: if (acc) begin
        cnt_d   = N_M'({hi_q[3:0], byte_data});
        state_d = ({hi_q[3:0], byte_data} == 12'd0) ? ERROR : DATA_H;
      end
      DATA_H: if (acc) begin
        hi_d    = byte_data;
        state_d = DATA_L;
      end
      DATA_L: if (acc) begin
        data_d  = N_L'({hi_q, byte_data});
        state_d = WRITE;
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_q + 1'b1;
        state_d = (words_d == cnt_q) ? CHECK : DATA_H;
      end
      CHECK: if (acc) state_d = (byte_data == sum) ? DONE : ERROR;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mano_program_loader.sv
// tb_mano_program_loader: directed streams with hand-computed results, including wrap, zero count, CLR mid-load and throttled valid.
module tb_mano_program_loader;
  logic        master_clock = 1'b0, CLR = 1'b1, start = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_write, cpu_hold, load_done, load_error;
  logic [11:0] mem_address, words_loaded;
  logic [15:0] mem_data;
  int          n_checks = 0, n_fail = 0, base;
  logic [27:0] wlog[$];
  logic [7:0]  stream[$];

  mano_program_loader dut (
    .master_clock(master_clock), .CLR(CLR), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_address(mem_address),
    .mem_data(mem_data), .mem_write(mem_write), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 master_clock = ~master_clock;
  always @(posedge master_clock) if (mem_write) wlog.push_back({mem_address, mem_data});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wentry(input int idx);
    return (idx < wlog.size()) ? {4'h0, wlog[idx]} : 32'hFFFF_FFFF;
  endfunction

  task automatic pulse_start;
    start = 1'b1;
    @(posedge master_clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int  guard = 0;
    bit  acc = 1'b0;
    byte_data = b;
    do begin
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = rnd && ($urandom_range(0, 3) == 0);
      @(negedge master_clock);
      acc = byte_valid && byte_ready;
      @(posedge master_clock); #1;
      start = 1'b0;
      guard++;
    end while (!acc && guard < 200);
    byte_valid = 1'b0;
    if (!acc) check("handshake_timeout", 0, 1);
  endtask

  task automatic send_stream(input bit rnd);
    foreach (stream[i]) send_byte(stream[i], rnd);
  endtask

  initial begin
    #1;
    check("rst_ready", byte_ready, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_error, 0);
    check("rst_write", mem_write, 0);
    check("rst_addr", mem_address, 0);
    check("rst_words", words_loaded, 0);
    @(posedge master_clock); #1;
    CLR = 1'b0;
    @(posedge master_clock); #1;

    base = wlog.size();
    pulse_start();
    check("start_hold", cpu_hold, 1);
    check("start_ready", byte_ready, 1);
    stream = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_stream(1'b0);
    check("ok_done", load_done, 1);
    check("ok_err", load_error, 0);
    check("ok_hold", cpu_hold, 0);
    check("ok_words", words_loaded, 2);
    check("ok_nwr", wlog.size() - base, 2);
    check("ok_w0", wentry(base), 32'h0010_1234);
    check("ok_w1", wentry(base + 1), 32'h0011_ABCD);

    base = wlog.size();
    pulse_start();
    check("restart_done_clr", load_done, 0);
    check("restart_words_clr", words_loaded, 0);
    stream[8] = 8'h41;
    send_stream(1'b0);
    check("bad_err", load_error, 1);
    check("bad_done", load_done, 0);
    check("bad_hold", cpu_hold, 1);
    check("bad_nwr", wlog.size() - base, 2);
    check("bad_w0", wentry(base), 32'h0010_1234);
    check("bad_w1", wentry(base + 1), 32'h0011_ABCD);
    repeat (3) @(posedge master_clock);
    #1 check("bad_sticky", load_error, 1);

    base = wlog.size();
    pulse_start();
    check("restart_err_clr", load_error, 0);
    stream = '{8'h0F, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03};
    send_stream(1'b0);
    check("wrap_done", load_done, 1);
    check("wrap_w0", wentry(base), 32'h0FFF_0001);
    check("wrap_w1", wentry(base + 1), 32'h0000_0002);

    base = wlog.size();
    pulse_start();
    stream = '{8'h00, 8'h20, 8'h00, 8'h00};
    send_stream(1'b0);
    check("zero_err", load_error, 1);
    repeat (3) @(posedge master_clock);
    #1 check("zero_nwr", wlog.size() - base, 0);

    base = wlog.size();
    pulse_start();
    stream = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_stream(1'b0);
    check("clr_pre_words", words_loaded, 1);
    CLR = 1'b1;
    #1;
    check("clr_state_ready", byte_ready, 0);
    check("clr_hold", cpu_hold, 0);
    check("clr_write", mem_write, 0);
    check("clr_addr", mem_address, 0);
    check("clr_data", mem_data, 0);
    check("clr_words", words_loaded, 0);
    check("clr_done", load_done, 0);
    check("clr_err", load_error, 0);
    @(posedge master_clock); #1;
    CLR = 1'b0;
    repeat (2) @(posedge master_clock);
    #1 check("clr_nwr", wlog.size() - base, 1);
    base = wlog.size();
    pulse_start();
    stream = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_stream(1'b0);
    check("after_clr_done", load_done, 1);
    check("after_clr_w0", wentry(base), 32'h0010_1234);
    check("after_clr_w1", wentry(base + 1), 32'h0011_ABCD);

    base = wlog.size();
    pulse_start();
    send_stream(1'b1);
    check("rnd_done", load_done, 1);
    check("rnd_hold", cpu_hold, 0);
    check("rnd_words", words_loaded, 2);
    check("rnd_nwr", wlog.size() - base, 2);
    check("rnd_w0", wentry(base), 32'h0010_1234);
    check("rnd_w1", wentry(base + 1), 32'h0011_ABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
